neuron_mac_q15: RTL and testbench

Serial multiply-accumulate neuron for the generator's final 3x3 layer, operating in Q1.15. It consumes N_IN input/weight pairs over a valid/ready stream and adds a bias. The wide sum is rescaled and saturated back to Q1.15, then the single result is presented on a valid/ready output. That output feeds the tanh activation stage directly.

---
 rtl/q15_pkg.sv | 15 +
 rtl/sat_round_q15.sv | 45 ++++
 rtl/neuron_mac_q15.sv | 106 ++++++++++
 tb/tb_neuron_mac_q15.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/q15_pkg.sv
// Shared Q1.15 constants and the MAC neuron state encoding.
package q15_pkg;

   localparam logic signed [15:0] Q15_MAX  = 16'sh7FFF;
   localparam logic signed [15:0] Q15_MIN  = 16'sh8000;
   localparam int unsigned        Q15_FRAC = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      SCALE = 2'd2,
      OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/sat_round_q15.sv
// Wide Q2.30-aligned accumulator to Q1.15: optional round-half-up, arithmetic shift, clip.
// Rounding is enabled by defining NEURON_ROUND_EN.
module sat_round_q15
   import q15_pkg::*;
#(
   parameter int unsigned ACC_W = 40
) (
   input  logic signed [ACC_W-1:0] i_acc,
   output logic signed [15:0]      o_y_c,
   output logic                    o_sat_c
);

   // One guard bit keeps the rounding add from wrapping at the top of the range.
   localparam int unsigned EXT_W = ACC_W + 1;
   localparam logic signed [EXT_W-1:0] W_MAX = EXT_W'(Q15_MAX);
   localparam logic signed [EXT_W-1:0] W_MIN = EXT_W'(Q15_MIN);

   logic signed [EXT_W-1:0] w_ext;
   logic signed [EXT_W-1:0] w_rnd;
   logic signed [EXT_W-1:0] w_shift;

   assign w_ext = EXT_W'(i_acc);

`ifdef NEURON_ROUND_EN
   localparam logic signed [EXT_W-1:0] W_HALF = EXT_W'(1) << (Q15_FRAC - 1);
   assign w_rnd = w_ext + W_HALF;
`else
   assign w_rnd = w_ext;
`endif

   assign w_shift = w_rnd >>> Q15_FRAC;

   always_comb begin
      o_y_c   = w_shift[15:0];
      o_sat_c = 1'b0;
      if (w_shift > W_MAX) begin
         o_y_c   = Q15_MAX;
         o_sat_c = 1'b1;
      end else if (w_shift < W_MIN) begin
         o_y_c   = Q15_MIN;
         o_sat_c = 1'b1;
      end
   end

endmodule

// File: rtl/neuron_mac_q15.sv
// Serial Q1.15 multiply-accumulate neuron with bias, saturating rescale and valid/ready output.
// Define NEURON_ROUND_EN for round-half-up before the final shift (otherwise truncation).
module neuron_mac_q15
   import q15_pkg::*;
#(
   parameter int unsigned N_IN  = 9,
   parameter int unsigned ACC_W = 40
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic signed [15:0] i_bias,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic signed [15:0] i_x,
   input  logic signed [15:0] i_w,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic signed [15:0] o_y,
   output logic               o_sat_flag,
   output logic               o_busy
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_IN - 1);

   state_t                   r_state;
   logic signed [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]         r_cnt;
   logic signed [15:0]       r_y;
   logic                     r_sat;
   logic                     r_out_valid;
   logic                     r_in_ready;
   logic                     r_busy;

   logic signed [31:0]       w_prod;
   logic signed [15:0]       w_y;
   logic                     w_sat;

   // Full Q2.30 product; -1.0 * -1.0 = +1.0 fits in 32 signed bits.
   assign w_prod = i_x * i_w;

   sat_round_q15 #(.ACC_W(ACC_W)) u_sat_round (
      .i_acc   (r_acc),
      .o_y_c   (w_y),
      .o_sat_c (w_sat)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_y         <= '0;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_acc      <= ACC_W'(i_bias) <<< Q15_FRAC;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ACC;
               end
            end
            ACC: begin
               if (i_in_valid) begin
                  r_acc <= r_acc + ACC_W'(w_prod);
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == LAST_BEAT) begin
                     r_in_ready <= 1'b0;
                     r_state    <= SCALE;
                  end
               end
            end
            SCALE: begin
               r_y         <= w_y;
               r_sat       <= w_sat;
               r_out_valid <= 1'b1;
               r_state     <= OUT;
            end
            OUT: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_y         = r_y;
   assign o_sat_flag  = r_sat;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_neuron_mac_q15.sv
// Table-driven scoreboard bench for neuron_mac_q15 (expectations follow NEURON_ROUND_EN).
module tb_neuron_mac_q15;

   localparam int unsigned N_IN = 9;

   typedef struct packed {
      logic [15:0]       bias;
      logic [8:0][15:0]  xs;
      logic [8:0][15:0]  ws;
      logic [15:0]       ey;
      logic              esat;
   } vec_t;

   typedef struct packed {
      logic [15:0] y;
      logic        sat;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic signed [15:0] bias;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] x;
   logic signed [15:0] w;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] y;
   logic               sat_flag;
   logic               busy;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tv[8];
   exp_t sb[$];

   always #5 clk = ~clk;

   neuron_mac_q15 #(.N_IN(N_IN), .ACC_W(40)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_bias      (bias),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_x         (x),
      .i_w         (w),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_y         (y),
      .o_sat_flag  (sat_flag),
      .o_busy      (busy)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  16'(in_ready),  16'h0);
      chk({tag, "_out_valid"}, 16'(out_valid), 16'h0);
      chk({tag, "_y"},         y,              16'h0000);
      chk({tag, "_sat"},       16'(sat_flag),  16'h0);
      chk({tag, "_busy"},      16'(busy),      16'h0);
   endtask

   // One full transaction; optional bubbles (with ignored start/in_valid noise) and output backpressure.
   task automatic run_vec(input vec_t v, input bit bubbles, input bit bp, input string tag);
      exp_t e;
      bit   seen;
      e.y   = v.ey;
      e.sat = v.esat;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1;
      bias  = v.bias;
      @(negedge clk);
      start = 1'b0;
      bias  = 16'sh5555;
      chk({tag, "_in_ready_after_start"}, 16'(in_ready), 16'h1);
      chk({tag, "_busy_after_start"},     16'(busy),     16'h1);
      for (int i = 0; i < int'(N_IN); i++) begin
         in_valid = 1'b1;
         x = v.xs[i];
         w = v.ws[i];
         @(negedge clk);
         if (bubbles) begin
            in_valid = 1'b0;
            x = 16'sh7FFF;
            w = 16'sh7FFF;
            start = (i == 2);
            bias  = 16'sh7FFF;
            @(negedge clk);
            start = 1'b0;
         end
      end
      in_valid = bubbles;
      x = 16'sh7FFF;
      w = 16'sh7FFF;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (out_valid) seen = 1'b1;
         else @(negedge clk);
      end
      in_valid = 1'b0;
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: out_valid=0 after 40 cycles, expected 1", tag);
         void'(sb.pop_front());
         return;
      end
      if (bp) begin
         for (int j = 0; j < 5; j++) begin
            chk({tag, "_hold_y"},         y,               sb[0].y);
            chk({tag, "_hold_sat"},       16'(sat_flag),   16'(sb[0].sat));
            chk({tag, "_hold_out_valid"}, 16'(out_valid),  16'h1);
            chk({tag, "_hold_in_ready"},  16'(in_ready),   16'h0);
            start = (j == 1);
            @(negedge clk);
            start = 1'b0;
         end
      end
      e = sb.pop_front();
      chk({tag, "_y"},        y,             e.y);
      chk({tag, "_sat"},      16'(sat_flag), 16'(e.sat));
      chk({tag, "_in_ready"}, 16'(in_ready), 16'h0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_out_valid_after_hs"}, 16'(out_valid), 16'h0);
      chk({tag, "_busy_after_hs"},      16'(busy),      16'h0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         tv[i].xs = '0;
         tv[i].ws = '0;
      end
      // 0.125 + 0.5*0.5 = 0.375
      tv[0].bias = 16'h1000; tv[0].xs[0] = 16'h4000; tv[0].ws[0] = 16'h4000;
      tv[0].ey = 16'h3000; tv[0].esat = 1'b0;
      // nine times (-1)*(-1) = +9.0
      tv[1].bias = 16'h0000;
      for (int i = 0; i < 9; i++) begin tv[1].xs[i] = 16'h8000; tv[1].ws[i] = 16'h8000; end
      tv[1].ey = 16'h7FFF; tv[1].esat = 1'b1;
      // nine times (-1)*(~1) = about -9.0
      tv[2].bias = 16'h0000;
      for (int i = 0; i < 9; i++) begin tv[2].xs[i] = 16'h8000; tv[2].ws[i] = 16'h7FFF; end
      tv[2].ey = 16'h8000; tv[2].esat = 1'b1;
      // half an LSB: rounds up or truncates away
      tv[3].bias = 16'h0000; tv[3].xs[0] = 16'h0001; tv[3].ws[0] = 16'h4000;
`ifdef NEURON_ROUND_EN
      tv[3].ey = 16'h0001;
`else
      tv[3].ey = 16'h0000;
`endif
      tv[3].esat = 1'b0;
      // negative bias alone passes through exactly
      tv[4].bias = 16'hF000; tv[4].ey = 16'hF000; tv[4].esat = 1'b0;
      // four beats of 0.25 * -0.5 = -0.5
      tv[5].bias = 16'h0000;
      for (int i = 0; i < 4; i++) begin tv[5].xs[i] = 16'h2000; tv[5].ws[i] = 16'hC000; end
      tv[5].ey = 16'hC000; tv[5].esat = 1'b0;
      // minus half an LSB: truncation floors to -1, rounding gives 0
      tv[6].bias = 16'h0000; tv[6].xs[0] = 16'hFFFF; tv[6].ws[0] = 16'h4000;
`ifdef NEURON_ROUND_EN
      tv[6].ey = 16'h0000;
`else
      tv[6].ey = 16'hFFFF;
`endif
      tv[6].esat = 1'b0;
      // max bias plus just under one LSB: rounding pushes it over the top
      tv[7].bias = 16'h7FFF; tv[7].xs[0] = 16'h0001; tv[7].ws[0] = 16'h7FFF;
      tv[7].ey = 16'h7FFF;
`ifdef NEURON_ROUND_EN
      tv[7].esat = 1'b1;
`else
      tv[7].esat = 1'b0;
`endif

      rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
      x = '0; w = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(tv[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

      run_vec(tv[0], 1'b1, 1'b1, "bubble_nominal");
      run_vec(tv[2], 1'b1, 1'b1, "bubble_negsat");
      run_vec(tv[7], 1'b0, 1'b0, "preload_y");

      // Abort mid-accumulation; the stale partial sum must not leak into the next run.
      @(negedge clk);
      start = 1'b1;
      bias  = 16'h1000;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         x = 16'sh4000;
         w = 16'sh4000;
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_acc_rst");
      rst = 1'b0;
      run_vec(tv[0], 1'b0, 1'b0, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
